// File: rtl/link_ingress_buf.sv
`default_nettype none
// ============================================================================
//  Module      : link_ingress_buf
//  Description : Router-side ingress buffer for one NI-to-router link.
//                Captures the NI flit stream into a show-ahead FIFO, drives
//                channel_busy back to the NI, and presents the head flit to
//                the crossbar with a valid/ready handshake.
//                Optional feature macro: LINK_PARITY_CHECK_EN
//                  defined   -> flits with bad parity (MSB) are dropped,
//                               flagged and counted
//                  undefined -> every requested flit is stored as-is
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module link_ingress_buf #(
    parameter int AW    = 2,
    parameter int ERR_W = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]    in_item,
    input  logic                                  in_req,
    output logic                                  channel_busy,
    output logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]    out_item,
    output logic [`ADDR_SZ-1:0]                   out_dest,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overflow,
    output logic                                  parity_err,
    output logic [ERR_W-1:0]                      err_cnt
);

    localparam int             c_W         = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int             c_DEPTH     = 2 ** AW;
    localparam logic [AW:0]    c_FULL_CNT  = (AW + 1)'(c_DEPTH);
    localparam logic [AW:0]    c_BUSY_CNT  = (AW + 1)'(c_DEPTH - 1);

    logic [c_W-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW:0]    r_count;
    logic           r_overflow;

    logic           w_parity_good;
    logic           w_push_ok;
    logic           w_full;
    logic           w_pop;
    logic           w_push;

`ifdef LINK_PARITY_CHECK_EN
    // MSB carries the parity of the remaining bits
    assign w_parity_good = (in_item[c_W-1] == ^in_item[c_W-2:0]);
`else
    assign w_parity_good = 1'b1;
`endif

    assign w_push_ok = in_req & w_parity_good;
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_pop     = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_push    = ~reset & w_push_ok & (~w_full | w_pop);

    // Busy one entry early: the NI already has one flit in flight when it sees busy
    assign channel_busy = reset | (r_count >= c_BUSY_CNT);

    assign out_valid = (r_count != '0);
    assign out_item  = r_mem[r_rd_ptr];
    assign out_dest  = out_item[`ADDR_SZ-1:0];
    assign overflow  = r_overflow;

    // Storage array; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_item;
        end
    end

    // Pointers and occupancy; pointer width makes wrap-around implicit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag: a good flit arrived while full with no head leaving
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_ok && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef LINK_PARITY_CHECK_EN
    logic             r_parity_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_reject;

    assign w_reject   = in_req & ~w_parity_good;
    assign parity_err = r_parity_err;
    assign err_cnt    = r_err_cnt;

    // One-cycle reject pulse and saturating reject counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity_err <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_parity_err <= w_reject;
            if (w_reject && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end
`else
    assign parity_err = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_link_ingress_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_ingress_buf
//  Description : Self-checking bench for link_ingress_buf. A queue-based
//                reference model pushes expected flits into a scoreboard;
//                a negedge monitor pops and compares whenever the DUT hands
//                over a flit, and checks the status outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_link_ingress_buf;

    localparam int AW    = 2;
    localparam int ERR_W = 3;
    localparam int DEPTH = 2 ** AW;
    localparam int AD    = `ADDR_SZ;
    localparam int W     = `HDR_SZ + `PL_SZ + `ADDR_SZ;

    logic             clk;
    logic             reset;
    logic [W-1:0]     in_item;
    logic             in_req;
    logic             channel_busy;
    logic [W-1:0]     out_item;
    logic [AD-1:0]    out_dest;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic             parity_err;
    logic [ERR_W-1:0] err_cnt;

    link_ingress_buf #(.AW(AW), .ERR_W(ERR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_item      (in_item),
        .in_req       (in_req),
        .channel_busy (channel_busy),
        .out_item     (out_item),
        .out_dest     (out_dest),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .parity_err   (parity_err),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pop_cnt  = 0;
    bit started  = 1'b0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           m_cnt  = 0;
    bit           m_ovf  = 1'b0;
    bit           m_perr = 1'b0;
    int           m_err  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [W-2:0] body, input bit bad);
        return {(^body) ^ bad, body};
    endfunction

    function automatic bit parity_ok(input logic [W-1:0] it);
`ifdef LINK_PARITY_CHECK_EN
        return it[W-1] == ^it[W-2:0];
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: FIFO occupancy rules applied at each rising edge
    always @(posedge clk) begin : model
        bit pop;
        started = 1'b1;
        if (reset) begin
            exp_q.delete();
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_perr = 1'b0;
            m_err  = 0;
        end else begin
            pop    = (m_cnt != 0) && out_ready;
            m_perr = in_req && !parity_ok(in_item);
            if (m_perr && m_err < (2 ** ERR_W - 1)) m_err++;
            if (in_req && parity_ok(in_item)) begin
                if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back(in_item);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) m_cnt--;
        end
    end

    // Monitor: compare status every cycle, flits whenever a handover occurs
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", out_valid, (m_cnt != 0));
            check("channel_busy", channel_busy, (reset || m_cnt >= DEPTH - 1));
            check("overflow", overflow, m_ovf);
            check("parity_err", parity_err, m_perr);
            check("err_cnt", err_cnt, m_err);
            if (out_valid && out_ready && !reset) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", 1, 0);
                end else begin
                    check("out_item", out_item, exp_q[0]);
                    check("out_dest", out_dest, exp_q[0][AD-1:0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        in_req    = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) tick();
        out_ready = 1'b0;
    endtask

    initial begin : stim
        bit b;
        bit b_next;
        int p0;
        reset     = 1'b1;
        in_req    = 1'b1;
        out_ready = 1'b0;
        in_item   = mk(W'($urandom), 1'b0);

        // Reset held three cycles while the NI keeps requesting
        repeat (3) begin
            tick();
            check("rst_busy", channel_busy, 1);
            check("rst_valid", out_valid, 0);
            check("rst_errcnt", err_cnt, 0);
            in_item = mk(W'($urandom), 1'b0);
        end
        reset  = 1'b0;
        in_req = 1'b0;
        repeat (2) tick();
        check("post_rst_empty", out_valid, 0);

        // Single flit: payload 5, dest 1
        out_ready = 1'b1;
        in_req    = 1'b1;
        in_item   = mk((W-1)'((5 << AD) | 1), 1'b0);
        tick();
        in_req = 1'b0;
        check("lat_valid", out_valid, 1);
        check("lat_dest", out_dest, 1);
        tick();
        check("lat_gone", out_valid, 0);
        out_ready = 1'b0;

        // Fill with a well-behaved NI that lags busy by one cycle
        b = channel_busy;
        repeat (10) begin
            in_req  = !b;
            in_item = mk(W'($urandom), 1'b0);
            @(negedge clk);
            b_next = channel_busy;
            tick();
            b = b_next;
        end
        in_req = 1'b0;
        tick();
        check("fill_busy", channel_busy, 1);
        check("fill_no_ovf", overflow, 0);
        p0 = pop_cnt;
        drain(8);
        check("fill_stored", pop_cnt - p0, DEPTH);

        // Forced overflow: NI ignores busy for six cycles
        in_req = 1'b1;
        repeat (6) begin
            in_item = mk(W'($urandom), 1'b0);
            tick();
        end
        in_req = 1'b0;
        check("ovf_flag", overflow, 1);
        p0 = pop_cnt;
        drain(8);
        check("ovf_stored", pop_cnt - p0, DEPTH);
        check("ovf_sticky", overflow, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Simultaneous push and pop while full
        in_req = 1'b1;
        repeat (DEPTH) begin
            in_item = mk(W'($urandom), 1'b0);
            tick();
        end
        p0        = pop_cnt;
        out_ready = 1'b1;
        in_item   = mk(W'($urandom), 1'b0);
        tick();
        in_req    = 1'b0;
        out_ready = 1'b0;
        tick();
        check("full_pp_busy", channel_busy, 1);
        check("full_pp_no_ovf", overflow, 0);
        drain(8);
        check("full_pp_pops", pop_cnt - p0, DEPTH + 1);

        // Three flits, the middle one with a flipped parity bit
        p0 = pop_cnt;
        in_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_item = mk(W'($urandom), (i == 1));
            tick();
        end
        in_req = 1'b0;
        tick();
`ifdef LINK_PARITY_CHECK_EN
        check("par_errcnt", err_cnt, 1);
        drain(6);
        check("par_pops", pop_cnt - p0, 2);
`else
        check("par_errcnt", err_cnt, 0);
        drain(6);
        check("par_pops", pop_cnt - p0, 3);
`endif

        // Randomised traffic with occasional resets and bad parity
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            in_req    = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_item   = mk(W'($urandom), ($urandom_range(0, 3) == 0));
            tick();
        end
        reset = 1'b0;
        drain(10);
        check("final_empty", out_valid, 0);
        check("final_leftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/link_ingress_buf.md
Name: link_ingress_buf

Overview:
- Router-side ingress stage directly downstream of the network interface (NI).
- Captures the NI's registered item_out/req stream into a small show-ahead FIFO and checks the parity bit of each flit.
- Drives channel_busy back to the NI as flow control, and presents buffered flits to the router crossbar with a valid/ready handshake.
- One instance per NI-to-router link.

Parameters:
- AW, 2, FIFO address width; depth DEPTH = 2**AW; AW >= 1 (DEPTH >= 2).
- ERR_W, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_item  in  W  flit from the NI item_out; W = `HDR_SZ+`PL_SZ+`ADDR_SZ; MSB is the parity bit.
- in_req  in  1  NI req; flit valid this cycle.
- channel_busy  out  1  backpressure to the NI.
- out_item  out  W  head flit.
- out_dest  out  `ADDR_SZ  head flit bits [`ADDR_SZ-1:0].
- out_valid  out  1  head flit present.
- out_ready  in  1  router consumes head when out_valid & out_ready.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.
- parity_err  out  1  one-cycle pulse per flit rejected for parity.
- err_cnt  out  ERR_W  saturating count of parity rejects.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high; clk/reset naming follows the codebase.
  - At the first edge with reset=1: count, rd_ptr, wr_ptr = 0; overflow = 0; parity_err = 0; err_cnt = 0; out_valid = 0.
  - Reset mid-operation discards all buffered flits; out_item content is don't-care.
- channel_busy:
  - Combinational: channel_busy = reset | (count >= DEPTH-1).
  - It is held high during reset so the NI cannot launch.
  - Threshold DEPTH-1 absorbs the one flit in flight, because the NI samples !channel_busy at edge k and drives req during cycle k+1.
- Push qualification: push_ok = in_req & parity_good, where parity_good = (in_item[W-1] == ^in_item[W-2:0]).
- Push:
  - If push_ok and (count < DEPTH, or pop in the same cycle): write at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
  - If push_ok, count == DEPTH and no pop: flit dropped, overflow <= 1 (sticky until reset), pointers unchanged.
- Pop: pop = out_valid & out_ready; rd_ptr+1 (wraps mod DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH, never below 0.
- Output (show-ahead):
  - out_valid = (count != 0); out_item = mem[rd_ptr]; out_dest = out_item[`ADDR_SZ-1:0].
  - Latency: a flit accepted at edge k is visible on out_item with out_valid=1 during cycle k+1.
- Empty case: no pop is possible (out_valid=0), so a push into an empty FIFO never bypasses to the output in the same cycle.
- Full case: push with a same-cycle pop is accepted; count stays DEPTH.
- Parity reject, when in_req & !parity_good:
  - Flit not written; parity_err <= 1 for one cycle.
  - err_cnt <= err_cnt+1, saturating at 2**ERR_W-1.
  - Otherwise parity_err <= 0.
- Ordering: FIFO order is preserved; no reordering or duplication.

Optional Feature:
- Macro: LINK_PARITY_CHECK_EN.
- Defined: parity checked as above; bad flits dropped, counted and flagged.
- Undefined:
  - parity_good is treated as 1; every in_req flit is pushed, parity bit stored unchanged.
  - parity_err is tied 0 and err_cnt is tied 0; no parity logic is synthesised.

Test Plan:
- Reset behaviour: hold reset 3 cycles with in_req=1 -> channel_busy=1 throughout, out_valid=0, err_cnt=0; nothing stored after reset drops.
- Single flit latency: AW=2, drive one even-parity flit, payload 5, dest 1, at edge 10 -> out_valid=1 and out_dest=1 in cycle 11; out_ready=1 pops it; out_valid=0 in cycle 12.
- Fill with backpressure: out_ready=0, NI model honours channel_busy with 1-cycle req lag -> channel_busy rises when count=3; exactly 4 flits stored; overflow stays 0.
- Forced overflow: out_ready=0, in_req held high for 6 cycles, ignoring busy -> count=4, overflow=1; drained sequence equals the first 4 flits in order.
- Parity reject (macro defined): flip the parity bit on flit 2 of 3 -> parity_err pulses once; err_cnt=1; output shows flits 1 and 3 only.
- Simultaneous push/pop at full: count=4, out_ready=1, valid push -> count remains 4, head advances, new flit appears at the tail.
